// File: rtl/mdio_seq_pkg.sv
// Shared definitions for the MDIO PHY sequencer.
// Contents: MAC management register byte addresses, MIICOMMAND encodings,
// PHY register/bit constants and the state enumerations used by the FSM.
package mdio_seq_pkg;

  localparam logic [7:0] ADR_MIIMODER   = 8'h14;
  localparam logic [7:0] ADR_MIIADDRESS = 8'h18;
  localparam logic [7:0] ADR_MIITXDATA  = 8'h1C;
  localparam logic [7:0] ADR_MIICOMMAND = 8'h20;
  localparam logic [7:0] ADR_MIISTATUS  = 8'h24;
  localparam logic [7:0] ADR_MIIRXDATA  = 8'h28;

  localparam logic [2:0] CMD_WRITE = 3'b100;
  localparam logic [2:0] CMD_READ  = 3'b010;

  localparam int         BUSY_BIT      = 1;
  localparam logic [4:0] BMSR_REG      = 5'd1;
  localparam int         BMSR_LINK_BIT = 2;

  typedef enum logic [2:0] {
    ST_CFG,
    ST_INIT,
    ST_IDLE,
    ST_OP,
    ST_FIN
  } top_state_e;

  typedef enum logic [2:0] {
    OP_W_ADDR,
    OP_W_DATA,
    OP_W_CMD,
    OP_P_CMD,
    OP_P_STAT,
    OP_R_DATA,
    OP_ABORT
  } op_state_e;

  typedef enum logic [1:0] {
    KIND_INIT,
    KIND_HOST,
    KIND_POLL
  } op_kind_e;

endpackage

// File: rtl/wb_single_master.sv
// Single-access Wishbone master.
// A start pulse (accepted only while no cycle is open) launches one access;
// address/we/data are registered and held until the slave acks. On ack the
// read data is captured, cyc/stb drop, and ack is pulsed for one cycle, so
// the bus is always idle for at least one cycle between accesses.
// Ports:
//   clk, rst           clock, synchronous active-high reset
//   start, we, adr,    access request (sampled when start=1 and bus idle)
//   wdata
//   ack, rdata         one-cycle completion pulse, captured read data
//   m_*                Wishbone master signals
module wb_single_master (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        we,
  input  logic [7:0]  adr,
  input  logic [31:0] wdata,
  output logic        ack,
  output logic [31:0] rdata,
  output logic        m_cyc,
  output logic        m_stb,
  output logic        m_we,
  output logic [7:0]  m_adr,
  output logic [31:0] m_dat_o,
  input  logic [31:0] m_dat_i,
  input  logic        m_ack
);

  always_ff @(posedge clk) begin
    if (rst) begin
      m_cyc   <= 1'b0;
      m_we    <= 1'b0;
      m_adr   <= 8'd0;
      m_dat_o <= 32'd0;
      ack     <= 1'b0;
      rdata   <= 32'd0;
    end else begin
      ack <= 1'b0;
      if (m_cyc) begin
        if (m_ack) begin
          m_cyc <= 1'b0;
          rdata <= m_dat_i;
          ack   <= 1'b1;
        end
      end else if (start) begin
        m_cyc   <= 1'b1;
        m_we    <= we;
        m_adr   <= adr;
        m_dat_o <= wdata;
      end
    end
  end

  assign m_stb = m_cyc;

endmodule

// File: rtl/mdio_phy_sequencer.sv
// MDIO PHY sequencer: Wishbone master over the MAC MII management block.
// After reset it programs MIIMODER, performs one PHY init write, then
// services host PHY read/write requests and periodic BMSR link polls.
// Ports:
//   wb_clk, wb_rst                  clock, synchronous active-high reset
//   m_cyc/m_stb/m_we/m_adr/m_dat_o  Wishbone master outputs
//   m_dat_i, m_ack                  Wishbone slave returns
//   req, req_we, req_reg, req_wdata host request (level, held until done)
//   done, rdata                     host completion pulse and read data
//   err                             abort pulse on polling-loop timeout
//   busy                            FSM not in IDLE
//   link_up, poll_cnt               last BMSR link bit, successful poll count
//
// state   | meaning
// --------+-------------------------------------------------------------
// CFG     | write MIIMODER = {NOPRE, MDC_DIV}
// INIT    | load the PHY init write into the op registers
// IDLE    | arbitrate host request (priority) vs expired poll timer
// OP      | run the MDIO sub-sequence (W_ADDR..R_DATA, or ABORT)
// FIN     | completion cycle; done/err visible, then back to IDLE
module mdio_phy_sequencer
  import mdio_seq_pkg::*;
#(
  parameter logic [4:0]  PHY_ADDR      = 5'd1,
  parameter logic [7:0]  MDC_DIV       = 8'd40,
  parameter logic        NOPRE         = 1'b0,
  parameter logic [4:0]  INIT_REG      = 5'd0,
  parameter logic [15:0] INIT_DATA     = 16'h1200,
  parameter logic [23:0] POLL_INTERVAL = 24'd1000000,
  parameter logic [15:0] TIMEOUT       = 16'd65535
) (
  input  logic        wb_clk,
  input  logic        wb_rst,
  output logic        m_cyc,
  output logic        m_stb,
  output logic        m_we,
  output logic [7:0]  m_adr,
  output logic [31:0] m_dat_o,
  input  logic [31:0] m_dat_i,
  input  logic        m_ack,
  input  logic        req,
  input  logic        req_we,
  input  logic [4:0]  req_reg,
  input  logic [15:0] req_wdata,
  output logic        done,
  output logic [15:0] rdata,
  output logic        err,
  output logic        busy,
  output logic        link_up,
  output logic [15:0] poll_cnt
);

  top_state_e  state_q, state_d;
  op_state_e   sub_q, sub_d;
  op_kind_e    kind_q;
  logic        pend_q, pend_d;
  logic        op_we_q;
  logic [4:0]  op_reg_q;
  logic [15:0] op_wdata_q;
  logic [23:0] poll_ctr_q;
  logic [15:0] to_cnt_q;
  logic        mask_q;

  logic        acc_start, acc_we, acc_ack;
  logic [7:0]  acc_adr;
  logic [31:0] acc_wdata, acc_rdata;
  logic        load_host, load_poll, load_init;
  logic        to_clr, fin_ok, err_set;
  logic        to_hit, cmd_issued;
  logic        unused_rd_hi;

  assign to_hit       = (to_cnt_q >= TIMEOUT);
  assign cmd_issued   = |(acc_rdata[2:0] & (op_we_q ? CMD_WRITE : CMD_READ));
  assign unused_rd_hi = ^acc_rdata[31:16];

  wb_single_master u_wbm (
    .clk     (wb_clk),
    .rst     (wb_rst),
    .start   (acc_start),
    .we      (acc_we),
    .adr     (acc_adr),
    .wdata   (acc_wdata),
    .ack     (acc_ack),
    .rdata   (acc_rdata),
    .m_cyc   (m_cyc),
    .m_stb   (m_stb),
    .m_we    (m_we),
    .m_adr   (m_adr),
    .m_dat_o (m_dat_o),
    .m_dat_i (m_dat_i),
    .m_ack   (m_ack)
  );

  always_comb begin
    state_d   = state_q;
    sub_d     = sub_q;
    pend_d    = acc_ack ? 1'b0 : pend_q;
    acc_start = 1'b0;
    acc_we    = 1'b0;
    acc_adr   = 8'd0;
    acc_wdata = 32'd0;
    load_host = 1'b0;
    load_poll = 1'b0;
    load_init = 1'b0;
    to_clr    = 1'b0;
    fin_ok    = 1'b0;
    err_set   = 1'b0;

    case (state_q)
      ST_CFG: begin
        acc_we    = 1'b1;
        acc_adr   = ADR_MIIMODER;
        acc_wdata = {23'd0, NOPRE, MDC_DIV};
        if (!pend_q) begin
          acc_start = 1'b1;
          pend_d    = 1'b1;
        end else if (acc_ack) begin
          state_d = ST_INIT;
        end
      end

      ST_INIT: begin
        load_init = 1'b1;
        sub_d     = OP_W_ADDR;
        state_d   = ST_OP;
      end

      ST_IDLE: begin
        // mask_q covers the cycle after FIN, when the host may still be
        // holding req for the op that just finished.
        if (!mask_q) begin
          if (req) begin
            load_host = 1'b1;
            sub_d     = OP_W_ADDR;
            state_d   = ST_OP;
          end else if (poll_ctr_q == 24'd0) begin
            load_poll = 1'b1;
            sub_d     = OP_W_ADDR;
            state_d   = ST_OP;
          end
        end
      end

      ST_OP: begin
        case (sub_q)
          OP_W_ADDR: begin
            acc_we    = 1'b1;
            acc_adr   = ADR_MIIADDRESS;
            acc_wdata = {19'd0, op_reg_q, 3'd0, PHY_ADDR};
            if (!pend_q) begin
              acc_start = 1'b1;
              pend_d    = 1'b1;
            end else if (acc_ack) begin
              sub_d = op_we_q ? OP_W_DATA : OP_W_CMD;
            end
          end
          OP_W_DATA: begin
            acc_we    = 1'b1;
            acc_adr   = ADR_MIITXDATA;
            acc_wdata = {16'd0, op_wdata_q};
            if (!pend_q) begin
              acc_start = 1'b1;
              pend_d    = 1'b1;
            end else if (acc_ack) begin
              sub_d = OP_W_CMD;
            end
          end
          OP_W_CMD: begin
            acc_we    = 1'b1;
            acc_adr   = ADR_MIICOMMAND;
            acc_wdata = {29'd0, (op_we_q ? CMD_WRITE : CMD_READ)};
            if (!pend_q) begin
              acc_start = 1'b1;
              pend_d    = 1'b1;
            end else if (acc_ack) begin
              sub_d  = OP_P_CMD;
              to_clr = 1'b1;
            end
          end
          OP_P_CMD: begin
            acc_adr = ADR_MIICOMMAND;
            // A timeout is only acted on between accesses, so an
            // outstanding read always completes first.
            if (!pend_q) begin
              if (to_hit) begin
                sub_d = OP_ABORT;
              end else begin
                acc_start = 1'b1;
                pend_d    = 1'b1;
              end
            end else if (acc_ack && !cmd_issued) begin
              sub_d  = OP_P_STAT;
              to_clr = 1'b1;
            end
          end
          OP_P_STAT: begin
            acc_adr = ADR_MIISTATUS;
            if (!pend_q) begin
              if (to_hit) begin
                sub_d = OP_ABORT;
              end else begin
                acc_start = 1'b1;
                pend_d    = 1'b1;
              end
            end else if (acc_ack && !acc_rdata[BUSY_BIT]) begin
              if (op_we_q) begin
                fin_ok  = 1'b1;
                state_d = ST_FIN;
              end else begin
                sub_d = OP_R_DATA;
              end
            end
          end
          OP_R_DATA: begin
            acc_adr = ADR_MIIRXDATA;
            if (!pend_q) begin
              acc_start = 1'b1;
              pend_d    = 1'b1;
            end else if (acc_ack) begin
              fin_ok  = 1'b1;
              state_d = ST_FIN;
            end
          end
          OP_ABORT: begin
            acc_we    = 1'b1;
            acc_adr   = ADR_MIICOMMAND;
            acc_wdata = 32'd0;
            if (!pend_q) begin
              acc_start = 1'b1;
              pend_d    = 1'b1;
            end else if (acc_ack) begin
              err_set = 1'b1;
              state_d = ST_FIN;
            end
          end
          default: sub_d = OP_W_ADDR;
        endcase
      end

      ST_FIN: state_d = ST_IDLE;

      default: state_d = ST_CFG;
    endcase
  end

  always_ff @(posedge wb_clk) begin
    if (wb_rst) begin
      state_q    <= ST_CFG;
      sub_q      <= OP_W_ADDR;
      kind_q     <= KIND_INIT;
      pend_q     <= 1'b0;
      op_we_q    <= 1'b0;
      op_reg_q   <= 5'd0;
      op_wdata_q <= 16'd0;
      poll_ctr_q <= POLL_INTERVAL - 24'd1;
      to_cnt_q   <= 16'd0;
      mask_q     <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
      rdata      <= 16'd0;
      busy       <= 1'b0;
      link_up    <= 1'b0;
      poll_cnt   <= 16'd0;
    end else begin
      state_q <= state_d;
      sub_q   <= sub_d;
      pend_q  <= pend_d;
      mask_q  <= (state_q == ST_FIN);
      busy    <= (state_d != ST_IDLE);

      if (load_init) begin
        kind_q     <= KIND_INIT;
        op_we_q    <= 1'b1;
        op_reg_q   <= INIT_REG;
        op_wdata_q <= INIT_DATA;
      end else if (load_host) begin
        kind_q     <= KIND_HOST;
        op_we_q    <= req_we;
        op_reg_q   <= req_reg;
        op_wdata_q <= req_wdata;
      end else if (load_poll) begin
        kind_q     <= KIND_POLL;
        op_we_q    <= 1'b0;
        op_reg_q   <= BMSR_REG;
        op_wdata_q <= 16'd0;
      end

      if (load_poll)
        poll_ctr_q <= POLL_INTERVAL - 24'd1;
      else if (poll_ctr_q != 24'd0)
        poll_ctr_q <= poll_ctr_q - 24'd1;

      if (to_clr)
        to_cnt_q <= 16'd0;
      else if (state_q == ST_OP && (sub_q == OP_P_CMD || sub_q == OP_P_STAT)
               && to_cnt_q != 16'hFFFF)
        to_cnt_q <= to_cnt_q + 16'd1;

      done <= fin_ok && (kind_q == KIND_HOST);
      err  <= err_set;

      if (fin_ok && kind_q == KIND_HOST && !op_we_q)
        rdata <= acc_rdata[15:0];

      if (fin_ok && kind_q == KIND_POLL) begin
        link_up  <= acc_rdata[BMSR_LINK_BIT];
        poll_cnt <= poll_cnt + 16'd1;
      end
    end
  end

endmodule

// File: doc/mdio_phy_sequencer.md
Name: mdio_phy_sequencer

Overview:
- Wishbone master that drives the MAC settings/MII management register block. It sequences complete MDIO transactions: address, data, command, completion polling and read-back.
- After reset it programs the MDC divider and performs one PHY init write. It then polls PHY register 1 (BMSR) periodically to report link state.
- It also shares the MDIO engine with a host request port; a host request has priority over the periodic poll.

Parameters:
- PHY_ADDR, 5'd1, PHY address placed in MIIADDRESS[4:0].
- MDC_DIV, 8'd40, divider written to MIIMODER[7:0].
- NOPRE, 1'b0, written to MIIMODER[8].
- INIT_REG, 5'd0, PHY register for the init write.
- INIT_DATA, 16'h1200, init write value (autoneg enable + restart).
- POLL_INTERVAL, 24'd1000000, wb_clk cycles between BMSR polls (≥2).
- TIMEOUT, 16'd65535, maximum cycles spent in any polling loop before abort.

Ports:
- wb_clk  in  1  clock
- wb_rst  in  1  synchronous active-high reset
- m_cyc  out  1  wishbone cycle
- m_stb  out  1  wishbone strobe
- m_we  out  1  write enable
- m_adr  out  8  byte address
- m_dat_o  out  32  write data
- m_dat_i  in  32  read data
- m_ack  in  1  slave acknowledge
- req  in  1  host request, level, held until done
- req_we  in  1  1 = PHY write, 0 = PHY read
- req_reg  in  5  PHY register address
- req_wdata  in  16  PHY write data
- done  out  1  one-cycle pulse; host op finished
- rdata  out  16  PHY read data, valid with done, held until next done
- err  out  1  one-cycle pulse; op aborted on TIMEOUT (host or internal)
- busy  out  1  high whenever the state machine is not in IDLE
- link_up  out  1  BMSR bit 2 from the last successful poll
- poll_cnt  out  16  count of successful polls, wraps at 0xFFFF

Behaviour:
- Clock and reset: one clock, wb_clk. Reset wb_rst is synchronous and active-high.
- Reset values: all outputs 0, state CFG, poll counter loaded with POLL_INTERVAL-1.
- Reset mid-transaction: m_cyc/m_stb drop on the next edge; the op is not resumed.
- Slave register map (byte addresses):
  - 0x14 MIIMODER {NoPre, Divider}
  - 0x18 MIIADDRESS {Rgad[12:8], Fiad[4:0]}
  - 0x1C MIITX_DATA
  - 0x20 MIICOMMAND [2]=write, [1]=read
  - 0x24 MIISTATUS [1]=Busy
  - 0x28 MIIRX_DATA
- Bus access:
  - One access at a time. m_cyc = m_stb, asserted with m_adr/m_we/m_dat_o stable until the cycle m_ack=1.
  - On ack, m_dat_i is sampled and m_cyc/m_stb are deasserted for at least one cycle before the next access.
  - Unused m_dat_o bits are 0.
- Top FSM:
  - CFG: write MIIMODER = {NOPRE, MDC_DIV}.
  - INIT: write op INIT_REG/INIT_DATA.
  - IDLE: arbitration per the rules below.
  - OP: sub-sequence.
  - FIN: completion actions per the rules below.
- IDLE arbitration:
  - If req=1, start a host op (req_we/req_reg/req_wdata captured this cycle).
  - Else if the poll counter is 0, start a poll read of reg 1 and reload the counter.
  - If both are pending in the same cycle, the host wins; the poll stays pending and runs on the next IDLE.
- Poll counter: decrements every cycle while nonzero, in all states; saturates at 0.
- OP sub-sequence:
  - W_ADDR: write 0x18 = {Rgad, 3'b0, Fiad}.
  - W_DATA: write 0x1C; write ops only.
  - W_CMD: write 0x20 = 3'b100 for write, 3'b010 for read.
  - P_CMD: read 0x20 repeatedly until the issued bit reads 0.
  - P_STAT: read 0x24 repeatedly until bit 1 = 0.
  - R_DATA: read 0x28; read ops only, captures [15:0].
- Timeout: a 16-bit counter clears on entry to P_CMD and P_STAT. Reaching TIMEOUT aborts:
  - Finish the outstanding bus access, then write 0x20 = 0.
  - Pulse err; return to IDLE.
  - No done, and no link_up or poll_cnt update.
  - A host op aborted this way must be re-requested by the host.
- FIN:
  - Host op: done pulse; rdata updated on reads only.
  - Poll: link_up ← data[2]; poll_cnt += 1.
  - Init: no pulse.
- Host handshake: done is asserted in the cycle the op completes. The host drops req within one cycle of done; req still high in IDLE two cycles later is treated as a new request.
- Host request during CFG/INIT: waits; serviced at the first IDLE.

Decomposition:
- Shared package mdio_seq_pkg:
  - byte-address constants ADR_MIIMODER…ADR_MIIRXDATA
  - command constants CMD_WRITE=3'b100, CMD_READ=3'b010
  - BUSY_BIT=1, BMSR_REG=5'd1, BMSR_LINK_BIT=2
  - state enumerations
- One sub-module, wb_single_master: issues one Wishbone access per start pulse and returns rdata and an ack pulse. The sequencer FSM sits above it.

Test Plan:
- Reset release against a register-block + PHY model → first accesses are: write 0x14 = 0x028; write 0x18 = 0x00000001; write 0x1C = 0x1200; write 0x20 = 0x4; then P_CMD/P_STAT polling; busy falls to 0.
- PHY BMSR = 0x786D (bit 2 = 1), POLL_INTERVAL = 100 → link_up=1, poll_cnt=1 within 100 + op latency cycles; with BMSR changed to 0x7869, next poll gives link_up=0, poll_cnt=2.
- Host read of reg 2 (PHYID1 = 0x0022) → one done pulse, rdata=0x0022, 0x1C never written.
- Host write of reg 4 = 0x01E1 → PHY model reg 4 = 0x01E1, done pulse, rdata unchanged.
- req and poll expiry in the same IDLE cycle → host op first, poll immediately after; exactly one done and poll_cnt +1.
- PHY model holds Busy=1 forever with TIMEOUT=50 → err pulse, last write 0x20 = 0, no done; next host op succeeds.
- wb_rst pulse while m_cyc=1 → m_cyc=0 next cycle, sequence restarts at CFG.
